interpolator: RTL and testbench
===============================

INTERPOLATOR -- requirements
Module: interpolator

Interface
REQ-001 Parameter R_LOG2, default 3, log2 of interpolation ratio R (R = 8); legal 1..5.
REQ-002 Parameter N_STAGES, default 3, CIC order N; legal 1..4.
REQ-003 s_axis_aclk  in  1  single clock; all logic on rising edge.
REQ-004 s_axis_areset  in  1  reset, asynchronous assert, active-high.
REQ-005 s_axis_tdata  in  24  signed two's-complement input sample.
REQ-006 s_axis_tvalid  in  1  input sample valid.
REQ-007 s_axis_tready  out  1  block accepts input sample.
REQ-008 s_axis_tuser  in  2  sideband; travels with its sample.
REQ-009 m_axis_tdata  out  24  signed interpolated output sample.
REQ-010 m_axis_tvalid  out  1  output sample valid.
REQ-011 m_axis_tready  in  1  downstream accepts output.
REQ-012 m_axis_tuser  out  2  tuser of the input sample that produced this output group.

Function
REQ-013 The block SHALL implement an N_STAGES CIC interpolator: N combs at input rate, zero-stuff by R, N integrators at output rate.
REQ-014 Each accepted input sample SHALL produce exactly R output samples, in order, none dropped or duplicated.
REQ-015 Input handshake = s_axis_tvalid & s_axis_tready; output handshake = m_axis_tvalid & m_axis_tready.
REQ-016 FSM states: IDLE (no group pending), EMIT (phase counter 0..R-1 issuing outputs).
REQ-017 IDLE -> EMIT on input handshake; EMIT -> IDLE when phase R-1 output is handed off and no new input is accepted in that cycle; EMIT -> EMIT (phase 0) when both happen together.
REQ-018 s_axis_tready SHALL be 1 in IDLE and in EMIT only in the cycle where phase R-1 is loaded into the output register and the output register is free (m_axis_tvalid=0 or m_axis_tready=1), so back-to-back groups run at full output rate.
REQ-019 Combs SHALL update only on input handshake; stage k width 24+k bits.
REQ-020 Integrators SHALL advance only when the output register loads; phase 0 feeds comb output, phases 1..R-1 feed zero.
REQ-021 Integrator width SHALL be 24+N_STAGES*R_LOG2 bits, two's-complement wrap allowed internally.
REQ-022 m_axis_tdata SHALL be the last integrator arithmetic-shifted right by (N_STAGES-1)*R_LOG2, low 24 bits (DC gain exactly 1).
REQ-023 Latency: first output of a group SHALL appear with m_axis_tvalid=1 exactly 2 cycles after its input handshake when m_axis_tready is held 1.
REQ-024 m_axis_tdata/tuser SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 m_axis_tuser SHALL equal the s_axis_tuser captured at the group's input handshake for all R outputs.
REQ-026 With continuous input and m_axis_tready=1, output throughput SHALL be one sample per cycle.

Reset
REQ-027 Reset SHALL clear combs, integrators, phase counter, FSM (IDLE), m_axis_tdata=0, m_axis_tuser=0, m_axis_tvalid=0, s_axis_tready=0 while asserted.
REQ-028 s_axis_tready SHALL rise the first cycle after reset deassertion.
REQ-029 Reset mid-group SHALL discard the remaining outputs; no partial group resumes afterwards.

Configuration
REQ-030 Macro INTERPOLATOR_TLAST_EN defined: output port m_axis_tlast (1 bit) exists, =1 exactly on phase R-1 output of each group, reset 0.
REQ-031 INTERPOLATOR_TLAST_EN undefined: port m_axis_tlast absent; all other behaviour identical.

Structure
REQ-032 Package interpolator_pkg SHALL hold DATA_W=24, USER_W=2, FSM state enum, and width-computation functions.
REQ-033 One sub-module interp_integrator (single accumulator stage with enable) SHALL be instantiated N_STAGES times.

Verification
REQ-034 DC: constant input 1000, m_axis_tready=1 -> after N_STAGES*R outputs every output = 1000.
REQ-035 Impulse: one sample 64 then zeros (R=8,N=3) -> output sum = 512, all outputs >= 0, 22 nonzero outputs.
REQ-036 Backpressure: m_axis_tready random 50 % -> output sequence identical to tready=1 run, tdata/tuser stable while stalled.
REQ-037 Latency/throughput: back-to-back inputs, tready=1 -> first tvalid 2 cycles after handshake, tvalid continuously 1, s_axis_tready every 8th cycle.
REQ-038 Reset mid-group: assert reset at phase 3 -> tvalid=0 same cycle, after release next input yields fresh 8-sample group from zero state.
REQ-039 tuser/tlast: tuser alternating 1,2 per input -> each 8-output group carries its value; with INTERPOLATOR_TLAST_EN tlast=1 only on 8th output.

Source files
------------

// File: rtl/interpolator_pkg.sv
// Shared constants, FSM state type and width helpers for the CIC interpolator.
package interpolator_pkg;

   localparam int unsigned DATA_W = 24;
   localparam int unsigned USER_W = 2;

   typedef enum logic [0:0] {
      StIdle,
      StEmit
   } state_e;

   // Comb stage k (1-based) grows by one bit per differencing step.
   function automatic int unsigned comb_width(input int unsigned stage);
      return DATA_W + stage;
   endfunction

   function automatic int unsigned integ_width(input int unsigned n_stages,
                                               input int unsigned r_log2);
      return DATA_W + n_stages * r_log2;
   endfunction

   // Removes the R^(N-1) gain left after zero-stuffing, giving unity DC gain.
   function automatic int unsigned out_shift(input int unsigned n_stages,
                                             input int unsigned r_log2);
      return (n_stages - 1) * r_log2;
   endfunction

endpackage

// File: rtl/interp_integrator.sv
// One CIC integrator stage: accumulates i_data when enabled; o_sum is the next value.
module interp_integrator
   import interpolator_pkg::*;
#(
   parameter int unsigned W = integ_width(3, 3)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] r_acc;

   // Exposing the post-add value lets the stages chain without extra delay.
   assign o_sum = r_acc + i_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= o_sum;
      end
   end

endmodule

// File: rtl/interpolator.sv
// CIC interpolator (N_STAGES combs, zero-stuff by 2^R_LOG2, N_STAGES integrators), AXI-Stream.
// Optional m_axis_tlast output when INTERPOLATOR_TLAST_EN is defined.
module interpolator
   import interpolator_pkg::*;
#(
   parameter int unsigned R_LOG2   = 3,
   parameter int unsigned N_STAGES = 3
) (
   input  logic                     s_axis_aclk,
   input  logic                     s_axis_areset,
   input  logic signed [DATA_W-1:0] s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [USER_W-1:0]        s_axis_tuser,
   output logic signed [DATA_W-1:0] m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [USER_W-1:0]        m_axis_tuser
`ifdef INTERPOLATOR_TLAST_EN
   ,
   output logic                     m_axis_tlast
`endif
);

   localparam int unsigned CW = comb_width(N_STAGES);
   localparam int unsigned IW = integ_width(N_STAGES, R_LOG2);
   localparam int unsigned SH = out_shift(N_STAGES, R_LOG2);
   localparam logic [R_LOG2-1:0] PHASE_LAST = '1;

   state_e                   r_state;
   state_e                   w_state_d;
   logic [R_LOG2-1:0]        r_phase;
   logic [R_LOG2-1:0]        w_phase_d;
   logic                     r_run;
   logic                     w_out_free;
   logic                     w_load;
   logic                     w_phase_last;
   logic                     w_s_ready;
   logic                     w_s_hs;
   logic signed [CW-1:0]     r_comb_out;
   logic [USER_W-1:0]        r_user;
   logic [IW-1:0]            w_int [0:N_STAGES];
   logic                     r_m_tvalid;
   logic signed [DATA_W-1:0] r_m_tdata;
   logic [USER_W-1:0]        r_m_tuser;

   // Handshake and load qualifiers
   assign w_out_free   = !r_m_tvalid || m_axis_tready;
   assign w_load       = (r_state == StEmit) && w_out_free;
   assign w_phase_last = (r_phase == PHASE_LAST);
   // Accepting on the last-phase load keeps back-to-back groups gapless.
   assign w_s_ready    = r_run && ((r_state == StIdle) || (w_load && w_phase_last));
   assign w_s_hs       = s_axis_tvalid && w_s_ready;

   assign s_axis_tready = w_s_ready;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tuser  = r_m_tuser;

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Comb section at input rate: stage k differences its input, widening by one bit.
   for (genvar k = 1; k <= N_STAGES; k++) begin : g_comb
      localparam int unsigned WI = comb_width(k - 1);

      logic signed [WI-1:0] w_in;
      logic signed [WI-1:0] r_dly;
      logic signed [WI:0]   w_out;

      if (k == 1) begin : g_src
         assign w_in = s_axis_tdata;
      end else begin : g_src
         assign w_in = g_comb[k-1].w_out;
      end

      assign w_out = {w_in[WI-1], w_in} - {r_dly[WI-1], r_dly};

      always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
         if (s_axis_areset) begin
            r_dly <= '0;
         end else if (w_s_hs) begin
            r_dly <= w_in;
         end
      end
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_comb_out <= '0;
         r_user     <= '0;
      end else if (w_s_hs) begin
         r_comb_out <= g_comb[N_STAGES].w_out;
         r_user     <= s_axis_tuser;
      end
   end

   // Zero-stuffing: only phase 0 injects the comb result into the integrators.
   assign w_int[0] = (r_phase == '0) ? IW'(r_comb_out) : '0;

   for (genvar k = 0; k < N_STAGES; k++) begin : g_int
      interp_integrator #(
         .W(IW)
      ) u_int (
         .i_clk (s_axis_aclk),
         .i_rst (s_axis_areset),
         .i_en  (w_load),
         .i_data(w_int[k]),
         .o_sum (w_int[k+1])
      );
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_state <= StIdle;
         r_phase <= '0;
      end else begin
         r_state <= w_state_d;
         r_phase <= w_phase_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_phase_d = r_phase;
      unique case (r_state)
         StIdle: begin
            if (w_s_hs) begin
               w_state_d = StEmit;
               w_phase_d = '0;
            end
         end
         StEmit: begin
            if (w_load) begin
               if (!w_phase_last) begin
                  w_phase_d = r_phase + 1'b1;
               end else if (w_s_hs) begin
                  w_phase_d = '0;
               end else begin
                  w_state_d = StIdle;
                  w_phase_d = '0;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
            w_phase_d = '0;
         end
      endcase
   end

   // Output register; the slice is the arithmetic shift right by SH, truncated to DATA_W.
   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tuser  <= '0;
      end else if (w_load) begin
         r_m_tvalid <= 1'b1;
         r_m_tdata  <= w_int[N_STAGES][SH +: DATA_W];
         r_m_tuser  <= r_user;
      end else if (m_axis_tready) begin
         r_m_tvalid <= 1'b0;
      end
   end

`ifdef INTERPOLATOR_TLAST_EN
   logic r_m_tlast;

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_m_tlast <= 1'b0;
      end else if (w_load) begin
         r_m_tlast <= w_phase_last;
      end
   end

   assign m_axis_tlast = r_m_tlast;
`endif

endmodule

// File: tb/tb_interpolator.sv
// Bench for interpolator: direct-convolution CIC reference model checked every output cycle,
// plus directed DC, impulse, backpressure, latency, reset and tuser/tlast scenarios.
module tb_interpolator;

   localparam int R_LOG2 = 3;
   localparam int N      = 3;
   localparam int R      = 1 << R_LOG2;
   localparam int SHIFT  = (N - 1) * R_LOG2;
   localparam int HLEN   = N * (R - 1) + 1;

   logic               clk      = 1'b0;
   logic               rst      = 1'b1;
   logic signed [23:0] s_tdata  = '0;
   logic               s_tvalid = 1'b0;
   logic               s_tready;
   logic [1:0]         s_tuser  = '0;
   logic signed [23:0] m_tdata;
   logic               m_tvalid;
   logic               m_tready = 1'b1;
   logic [1:0]         m_tuser;
`ifdef INTERPOLATOR_TLAST_EN
   logic               m_tlast;
`endif

   int     n_vec    = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   bit     bp       = 1'b0;
   bit     arm      = 1'b0;
   bit     stalled  = 1'b0;
   longint held_d   = 0;
   int     held_u   = 0;
   int     hs_first = -1;
   int     tv_first = -1;
   int     gaps     = 0;
   int     hs_cyc[$];

   int     h [HLEN];
   longint x_hist[$];
   int     exp_d[$];
   int     exp_u[$];
   int     exp_l[$];
   int     obs_d[$];
   int     obs_u[$];
   int     obs_l[$];
   int     ref_d[$];

   interpolator #(
      .R_LOG2  (R_LOG2),
      .N_STAGES(N)
   ) dut (
      .s_axis_aclk  (clk),
      .s_axis_areset(rst),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tuser (s_tuser),
      .m_axis_tdata (m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tuser (m_tuser)
`ifdef INTERPOLATOR_TLAST_EN
      ,
      .m_axis_tlast (m_tlast)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Impulse response of the whole chain: coefficients of (1 + z^-1 + ... + z^-(R-1))^N.
   task automatic build_h();
      int t [HLEN];
      int len;
      foreach (h[i]) h[i] = 0;
      h[0] = 1;
      len  = 1;
      for (int s = 0; s < N; s++) begin
         foreach (t[i]) t[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < R; j++) t[i+j] += h[i];
         len += R - 1;
         h = t;
      end
   endtask

   // Each accepted sample x[n] yields outputs y[nR+p] = (sum_i x[i]*h[nR+p-iR]) >>> SHIFT.
   task automatic model_push(input longint x, input int u);
      int          n;
      longint      acc;
      longint      y;
      logic [23:0] t;
      x_hist.push_back(x);
      n = x_hist.size() - 1;
      for (int p = 0; p < R; p++) begin
         acc = 0;
         for (int i = 0; i <= n; i++) begin
            int j = (n * R + p) - i * R;
            if (j >= 0 && j < HLEN) acc += x_hist[i] * h[j];
         end
         y = acc >>> SHIFT;
         t = y[23:0];
         exp_d.push_back(int'($signed(t)));
         exp_u.push_back(u);
         exp_l.push_back((p == R - 1) ? 1 : 0);
      end
   endtask

   // Compare process: every negedge, away from the active edge.
   always @(negedge clk) begin
      int ed, eu, el;
      if (rst) begin
         x_hist.delete();
         exp_d.delete();
         exp_u.delete();
         exp_l.delete();
         obs_d.delete();
         obs_u.delete();
         obs_l.delete();
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_tvalid", m_tvalid, 1);
            check("stall_tdata", m_tdata, held_d);
            check("stall_tuser", m_tuser, held_u);
         end
         if (m_tvalid && m_tready) begin
            check("output_expected", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
               ed = exp_d.pop_front();
               eu = exp_u.pop_front();
               el = exp_l.pop_front();
               check("tdata", m_tdata, ed);
               check("tuser", m_tuser, eu);
`ifdef INTERPOLATOR_TLAST_EN
               check("tlast", m_tlast, el);
`endif
            end
            obs_d.push_back(int'(m_tdata));
            obs_u.push_back(int'(m_tuser));
`ifdef INTERPOLATOR_TLAST_EN
            obs_l.push_back(int'(m_tlast));
`else
            obs_l.push_back(0);
`endif
         end
         stalled = m_tvalid && !m_tready;
         held_d  = m_tdata;
         held_u  = m_tuser;
         if (arm) begin
            if (s_tvalid && s_tready) begin
               if (hs_first < 0) hs_first = cyc;
               hs_cyc.push_back(cyc);
            end
            if (m_tvalid && tv_first < 0) tv_first = cyc;
            if (tv_first >= 0 && !m_tvalid && exp_d.size() > 0) gaps++;
         end
         if (s_tvalid && s_tready) model_push(longint'(s_tdata), int'(s_tuser));
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Callers are aligned to posedge+1; leaves s_tvalid high so bursts stay back-to-back.
   task automatic send(input int d, input int u);
      int k = 0;
      s_tdata  = 24'(d);
      s_tuser  = 2'(u);
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("send_accepted", s_tready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_obs(input int n, input string name);
      int k = 0;
      while (obs_d.size() < n && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      check({name, "_outputs_seen"}, obs_d.size() >= n, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1);
      s_tvalid = 1'b0;
      rst      = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq [6] = '{1000, -5000, 123456, -8388608, 8388607, 77};
      int sum, nz, neg, hsum;

      build_h();
      hsum = 0;
      foreach (h[i]) hsum += h[i];
      check("model_h0", h[0], 1);
      check("model_h1", h[1], 3);
      check("model_h7", h[7], 36);
      check("model_h8", h[8], 42);
      check("model_hsum", hsum, 512);

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tuser", m_tuser, 0);
`ifdef INTERPOLATOR_TLAST_EN
      check("rst_tlast", m_tlast, 0);
`endif
      tick(1);
      rst = 1'b0;
      tick(1);
      check("tready_after_reset", s_tready, 1);

      // DC
      for (int i = 0; i < 6; i++) send(1000, 0);
      s_tvalid = 1'b0;
      wait_obs(48, "dc");
      for (int i = N * R; i < 48; i++) check("dc_level", obs_d[i], 1000);

      // Impulse
      do_reset();
      send(64, 0);
      for (int i = 0; i < 3; i++) send(0, 0);
      s_tvalid = 1'b0;
      wait_obs(32, "impulse");
      sum = 0;
      nz  = 0;
      neg = 0;
      for (int i = 0; i < 32; i++) begin
         sum += obs_d[i];
         if (obs_d[i] != 0) nz++;
         if (obs_d[i] < 0) neg++;
      end
      check("impulse_sum", sum, 512);
      check("impulse_negatives", neg, 0);
      check("impulse_nonzero", nz, 22);
      check("impulse_y0", obs_d[0], 1);
      check("impulse_y1", obs_d[1], 3);
      check("impulse_y7", obs_d[7], 36);
      check("impulse_y8", obs_d[8], 42);

      // Reference run with tready=1, tuser alternating 1,2
      do_reset();
      for (int i = 0; i < 6; i++) send(seq[i], (i % 2 == 1) ? 2 : 1);
      s_tvalid = 1'b0;
      wait_obs(48, "ref_run");
      ref_d = obs_d;
      for (int g = 0; g < 6; g++) begin
         for (int p = 0; p < R; p++) begin
            check("group_tuser", obs_u[g*R+p], (g % 2 == 1) ? 2 : 1);
`ifdef INTERPOLATOR_TLAST_EN
            check("group_tlast", obs_l[g*R+p], (p == R - 1) ? 1 : 0);
`endif
         end
      end

      // Same sequence under random backpressure
      do_reset();
      bp = 1'b1;
      for (int i = 0; i < 6; i++) send(seq[i], (i % 2 == 1) ? 2 : 1);
      s_tvalid = 1'b0;
      wait_obs(48, "bp_run");
      bp = 1'b0;
      tick(1);
      for (int i = 0; i < 48; i++) check("bp_vs_ref", obs_d[i], ref_d[i]);

      // Latency and throughput with back-to-back inputs
      do_reset();
      hs_cyc.delete();
      hs_first = -1;
      tv_first = -1;
      gaps     = 0;
      arm      = 1'b1;
      for (int i = 1; i <= 5; i++) send(i * 100, 0);
      s_tvalid = 1'b0;
      wait_obs(40, "burst");
      arm = 1'b0;
      check("first_latency", tv_first - hs_first, 2);
      check("tvalid_gaps", gaps, 0);
      check("burst_handshakes", hs_cyc.size(), 5);
      for (int i = 1; i < 5; i++) check("hs_interval", hs_cyc[i] - hs_cyc[i-1], R);

      // Reset in the middle of a group
      do_reset();
      send(500, 1);
      s_tvalid = 1'b0;
      wait_obs(3, "pre_reset");
      #1;
      rst = 1'b1;
      #1;
      check("midrst_tvalid", m_tvalid, 0);
      check("midrst_s_tready", s_tready, 0);
      tick(2);
      rst = 1'b0;
      tick(4);
      check("post_rst_idle_tvalid", m_tvalid, 0);
      send(1000, 2);
      s_tvalid = 1'b0;
      wait_obs(8, "post_reset");
      tick(12);
      check("post_rst_count", obs_d.size(), 8);
      check("post_rst_y0", obs_d[0], 15);
      check("post_rst_y1", obs_d[1], 46);
      check("post_rst_tuser", obs_u[7], 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
